// File: rtl/mux_scan_nx1_if.sv
// mux_scan_nx1_if: handshake/data bundle for the N:1 scanning mux.
//   din/sel/mode/start/out_ready : requester -> mux
//   dout/dout_ch/dout_valid      : registered output beat, mux -> consumer
//   busy/scan_done               : scan status, mux -> requester
// master = the side driving requests, slave = the mux itself.
interface mux_scan_nx1_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 32,
  parameter int SEL_W    = 5
);
  logic [CHANNELS*WIDTH-1:0] din;
  logic [SEL_W-1:0]          sel;
  logic                      mode;
  logic                      start;
  logic                      out_ready;
  logic [WIDTH-1:0]          dout;
  logic [SEL_W-1:0]          dout_ch;
  logic                      dout_valid;
  logic                      busy;
  logic                      scan_done;

  modport master (
    output din, sel, mode, start, out_ready,
    input  dout, dout_ch, dout_valid, busy, scan_done
  );

  modport slave (
    input  din, sel, mode, start, out_ready,
    output dout, dout_ch, dout_valid, busy, scan_done
  );
endinterface

// File: rtl/mux_scan_nx1.sv
// mux_scan_nx1: CHANNELS-to-1 mux with a registered, ready/valid output.
// Manual mode samples one channel (din[sel]) per start; scan mode walks
// channels 0..CHANNELS-1, one beat per accepted output.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   bus       mux_scan_nx1_if.slave (din, sel, mode, start, out_ready in;
//             dout, dout_ch, dout_valid, busy, scan_done out)
// Build option: define MUX_SCAN_EN to include scan mode (SCAN state,
// channel counter, busy, scan_done). Without it mode is ignored and
// busy/scan_done are tied low.
// SEL_W is expected to equal clog2(CHANNELS).
module mux_scan_nx1 #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 32,
  parameter int SEL_W    = 5
) (
  input  logic           clk,
  input  logic           rst,
  mux_scan_nx1_if.slave  bus
);
  localparam int SLOTS = 2**SEL_W;

  // Channel table padded to the full select range; slots past CHANNELS
  // read as zero so an out-of-range index needs no separate compare.
  logic [WIDTH-1:0] ch_data [SLOTS];

  generate
    for (genvar k = 0; k < SLOTS; k++) begin : g_ch
      if (k < CHANNELS) begin : g_real
        assign ch_data[k] = bus.din[k*WIDTH +: WIDTH];
      end else begin : g_pad
        assign ch_data[k] = '0;
      end
    end
  endgenerate

  logic [WIDTH-1:0] dout_q;
  logic [SEL_W-1:0] dout_ch_q;
  logic             dout_valid_q;
  logic             load;

  // Output register may take a new beat when empty or being drained.
  assign load = !dout_valid_q || bus.out_ready;

  assign bus.dout       = dout_q;
  assign bus.dout_ch    = dout_ch_q;
  assign bus.dout_valid = dout_valid_q;

`ifdef MUX_SCAN_EN
  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS-1);

  state_t           state;
  logic [SEL_W-1:0] cnt;
  logic             last_q;  // current beat is the final beat of a scan

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      last_q       <= 1'b0;
      dout_q       <= '0;
      dout_ch_q    <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && bus.mode) begin
            // Scan entry ignores load; first beat comes from SCAN.
            state <= SCAN;
            cnt   <= '0;
            if (load) begin
              dout_valid_q <= 1'b0;
              last_q       <= 1'b0;
            end
          end else if (bus.start && load) begin
            dout_q       <= ch_data[bus.sel];
            dout_ch_q    <= bus.sel;
            dout_valid_q <= 1'b1;
            last_q       <= 1'b0;
          end else if (load) begin
            dout_valid_q <= 1'b0;
            last_q       <= 1'b0;
          end
        end
        SCAN: begin
          // din is sampled here, at load time, so stalls see fresh data.
          if (load) begin
            dout_q       <= ch_data[cnt];
            dout_ch_q    <= cnt;
            dout_valid_q <= 1'b1;
            last_q       <= (cnt == LAST_CH);
            if (cnt == LAST_CH) state <= IDLE;
            else                cnt   <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state == SCAN);
  // Pulses in the cycle the last scan beat is handed off.
  assign bus.scan_done = dout_valid_q && bus.out_ready && last_q;
`else
  logic unused_mode;
  assign unused_mode = bus.mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q       <= '0;
      dout_ch_q    <= '0;
      dout_valid_q <= 1'b0;
    end else if (load) begin
      if (bus.start) begin
        dout_q       <= ch_data[bus.sel];
        dout_ch_q    <= bus.sel;
        dout_valid_q <= 1'b1;
      end else begin
        dout_valid_q <= 1'b0;
      end
    end
  end

  assign bus.busy      = 1'b0;
  assign bus.scan_done = 1'b0;
`endif
endmodule

// File: tb/tb_mux_scan_nx1.sv
// tb_mux_scan_nx1: scoreboard bench for mux_scan_nx1. Expected beats are
// queued as stimulus is applied and popped as the DUT hands beats off.
// A second instance (CHANNELS=20) covers out-of-range selects.
module tb_mux_scan_nx1;
  localparam int W  = 8;
  localparam int CH = 32;
  localparam int SW = 5;

  typedef struct {
    logic [SW-1:0] ch;
    logic [W-1:0]  data;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst;
  int    errors = 0;
  int    checks = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  mux_scan_nx1_if #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) bus ();
  mux_scan_nx1_if #(.WIDTH(W), .CHANNELS(20), .SEL_W(SW)) bus2 ();

  mux_scan_nx1 #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  mux_scan_nx1 #(.WIDTH(W), .CHANNELS(20), .SEL_W(SW)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2));

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL rst_dout got=%h want=00", bus.dout); end
    checks++; if (bus.dout_ch !== 5'd0) begin errors++; $display("FAIL rst_dout_ch got=%0d want=0", bus.dout_ch); end
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b want=0", bus.dout_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
    checks++; if (bus.scan_done !== 1'b0) begin errors++; $display("FAIL rst_scan_done got=%b want=0", bus.scan_done); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid got=%b want=0", bus.dout_valid); end
  endtask

  task automatic test_manual(input logic mode_v, input logic [SW-1:0] s);
    beat_t e;
    exp_q.delete();
    @(negedge clk);
    bus.mode = mode_v; bus.sel = s; bus.start = 1'b1; bus.out_ready = 1'b1;
    exp_q.push_back('{s, 8'(s + 8'h10)});
    @(negedge clk);
    bus.start = 1'b0; bus.mode = 1'b0; #1;
    checks++;
    if (bus.dout_valid !== 1'b1) begin
      errors++; $display("FAIL manual_valid got=%b want=1", bus.dout_valid);
    end else begin
      e = exp_q.pop_front();
      checks++; if (bus.dout_ch !== e.ch) begin errors++; $display("FAIL manual_ch got=%0d want=%0d", bus.dout_ch, e.ch); end
      checks++; if (bus.dout !== e.data) begin errors++; $display("FAIL manual_dout got=%h want=%h", bus.dout, e.data); end
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL manual_busy got=%b want=0", bus.busy); end
    checks++; if (bus.scan_done !== 1'b0) begin errors++; $display("FAIL manual_scan_done got=%b want=0", bus.scan_done); end
    @(negedge clk); #1;
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL manual_valid_drop got=%b want=0", bus.dout_valid); end
    checks++; if (bus.dout !== 8'(s + 8'h10)) begin errors++; $display("FAIL manual_dout_hold got=%h want=%h", bus.dout, 8'(s + 8'h10)); end
  endtask

  task automatic test_hold_drop();
    @(negedge clk);
    bus.mode = 1'b0; bus.sel = 5'd3; bus.start = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk); #1;
    checks++; if (bus.dout_valid !== 1'b1 || bus.dout !== 8'h13) begin errors++; $display("FAIL hold_first got=%b/%h want=1/13", bus.dout_valid, bus.dout); end
    bus.sel = 5'd9;  // stays requested while stalled: must be dropped
    @(negedge clk); #1;
    checks++; if (bus.dout !== 8'h13 || bus.dout_ch !== 5'd3 || bus.dout_valid !== 1'b1) begin
      errors++; $display("FAIL hold_stall got=%h/%0d/%b want=13/3/1", bus.dout, bus.dout_ch, bus.dout_valid); end
    bus.start = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (bus.dout_valid !== 1'b0 || bus.dout_ch !== 5'd3) begin
      errors++; $display("FAIL hold_drop got=%b/%0d want=0/3", bus.dout_valid, bus.dout_ch); end
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    bus2.mode = 1'b0; bus2.sel = 5'd31; bus2.start = 1'b1; bus2.out_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (bus2.dout !== 8'h00 || bus2.dout_ch !== 5'd31 || bus2.dout_valid !== 1'b1) begin
      errors++; $display("FAIL oor_sel31 got=%h/%0d/%b want=00/31/1", bus2.dout, bus2.dout_ch, bus2.dout_valid); end
    bus2.sel = 5'd19;
    @(negedge clk); #1;
    checks++; if (bus2.dout !== 8'h23 || bus2.dout_ch !== 5'd19) begin
      errors++; $display("FAIL oor_sel19 got=%h/%0d want=23/19", bus2.dout, bus2.dout_ch); end
    bus2.start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_scan(input int stall_ch, input int stall_n, input int abort_ch, input int nscans);
    int    beats = 0, busy_cyc = 0, done_cnt = 0, holds = 0, first_v = -1;
    bit    aborted = 1'b0;
    beat_t e;
    exp_q.delete();
    for (int s = 0; s < nscans; s++)
      for (int k = 0; k < CH; k++) exp_q.push_back('{SW'(k), 8'(k + 16)});
    @(negedge clk);
    bus.mode = 1'b1; bus.start = 1'b1; bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (beats == nscans*CH && !bus.dout_valid && !bus.busy) break;
      if (abort_ch >= 0 && bus.dout_valid && int'(bus.dout_ch) == abort_ch) begin
        rst = 1'b1; #1;
        checks++; if ({bus.dout, bus.dout_ch, bus.dout_valid, bus.busy, bus.scan_done} !== '0) begin
          errors++; $display("FAIL abort_zero got=%h/%0d/%b/%b/%b want=all 0", bus.dout, bus.dout_ch, bus.dout_valid, bus.busy, bus.scan_done); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_done got=%0d want=0", done_cnt); end
        exp_q.delete(); aborted = 1'b1;
        @(negedge clk); rst = 1'b0;
        break;
      end
      if (nscans == 1 || beats >= CH + 1) bus.start = 1'b0;
      if (!bus.start) begin bus.mode = cyc[0]; bus.sel = SW'($urandom); end
      if (bus.busy) busy_cyc++;
      if (bus.dout_valid && first_v < 0) first_v = cyc;
      bus.out_ready = 1'b1;
      if (bus.dout_valid && int'(bus.dout_ch) == stall_ch && holds < stall_n) begin
        bus.out_ready = 1'b0; holds++;
        checks++; if (bus.dout !== 8'(stall_ch + 16)) begin errors++; $display("FAIL stall_hold got=%h want=%h", bus.dout, 8'(stall_ch + 16)); end
      end
      #1;
      if (bus.dout_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL scan_extra_beat got ch=%0d want=none", bus.dout_ch);
        end else begin
          e = exp_q.pop_front();
          if (bus.dout_ch !== e.ch || bus.dout !== e.data) begin
            errors++; $display("FAIL scan_beat got=%0d/%h want=%0d/%h", bus.dout_ch, bus.dout, e.ch, e.data); end
          checks++; if (bus.scan_done !== (e.ch == SW'(CH-1))) begin
            errors++; $display("FAIL scan_done_beat got=%b at ch=%0d want=%b", bus.scan_done, e.ch, e.ch == SW'(CH-1)); end
        end
        if (bus.scan_done) done_cnt++;
        beats++;
      end else begin
        checks++; if (bus.scan_done !== 1'b0) begin errors++; $display("FAIL scan_done_spurious got=1 want=0"); end
      end
    end
    bus.start = 1'b0; bus.mode = 1'b0;
    if (abort_ch >= 0) begin
      checks++; if (!aborted) begin errors++; $display("FAIL abort_reached got=0 want=1"); end
    end else begin
      checks++; if (beats != nscans*CH) begin errors++; $display("FAIL scan_beats got=%0d want=%0d", beats, nscans*CH); end
      checks++; if (done_cnt != nscans) begin errors++; $display("FAIL scan_done_cnt got=%0d want=%0d", done_cnt, nscans); end
      checks++; if (busy_cyc != nscans*CH + stall_n) begin errors++; $display("FAIL scan_busy_cyc got=%0d want=%0d", busy_cyc, nscans*CH + stall_n); end
      checks++; if (first_v != 1) begin errors++; $display("FAIL scan_latency got=%0d want=1", first_v); end
      checks++; if (holds != stall_n) begin errors++; $display("FAIL stall_cycles got=%0d want=%0d", holds, stall_n); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.mode = 1'b0; bus.sel = '0; bus.out_ready = 1'b1; bus.din = '0;
    bus2.start = 1'b0; bus2.mode = 1'b0; bus2.sel = '0; bus2.out_ready = 1'b1; bus2.din = '0;
    for (int k = 0; k < CH; k++) bus.din[k*W +: W] = 8'(k + 16);
    for (int k = 0; k < 20; k++) bus2.din[k*W +: W] = 8'(k + 16);
    test_reset();
    test_manual(1'b0, 5'd5);
    test_manual(1'b0, 5'd31);
    test_hold_drop();
    test_out_of_range();
`ifdef MUX_SCAN_EN
    test_scan(-1, 0, -1, 1);
    test_scan(7, 3, -1, 1);
    test_scan(-1, 0, 12, 1);
    test_scan(-1, 0, -1, 1);
    test_scan(-1, 0, -1, 2);
`else
    test_manual(1'b1, 5'd9);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
